rv32i_data_memory_controller: RTL and testbench



---
 rtl/rv32i_data_memory_controller_if.sv | 23 ++
 rtl/rv32i_data_memory_controller.sv | 173 +++++++++++++++++
 tb/tb_rv32i_data_memory_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_data_memory_controller_if.sv
// Request/response bus between the multicycle core (master) and the data-memory
// controller (slave): valid/ready request, registered load data, done/err status.
interface rv32i_data_memory_controller_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wr_ena;
  logic [2:0]  funct3;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        done;
  logic        err;

  modport master (
    output req_valid, addr, wr_ena, funct3, wr_data,
    input  req_ready, rd_data, done, err
  );

  modport slave (
    input  req_valid, addr, wr_ena, funct3, wr_data,
    output req_ready, rd_data, done, err
  );
endinterface

// File: rtl/rv32i_data_memory_controller.sv
// RV32I data-memory slave: sync-read word RAM, sign/zero-extended sub-word loads,
// read-modify-write sub-word stores. Optional macro DATA_MEM_BOUNDS_CHECK_EN.
module rv32i_data_memory_controller #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  rv32i_data_memory_controller_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RMW  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t              state;
  state_t              state_next;

  logic [31:0]         mem [DEPTH_WORDS];
  logic [31:0]         mem_q;
  logic                rd_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [31:0]         mem_wdata;

  logic [ADDR_W+1:0]   addr_q;
  logic [2:0]          funct3_q;
  logic [15:0]         wr_data_q;
  logic                err_q;
  logic [31:0]         rd_data_q;

  logic                accept;
  logic [ADDR_W-1:0]   req_idx;
  logic [1:0]          req_size;
  logic                funct3_ok;
  logic                misaligned;
  logic                out_of_bounds;
  logic                req_legal;
  logic [31:0]         load_fmt;
  logic [31:0]         merged;

  // Request decode on the incoming bus, valid only in the accepting cycle.
  assign accept   = ena && bus.req_valid && (state == IDLE);
  assign req_idx  = bus.addr[ADDR_W+1:2];
  assign req_size = bus.funct3[1:0];

  assign funct3_ok = bus.wr_ena ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                                : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misaligned = ((req_size == SIZE_HALF) && bus.addr[0]) ||
                      ((req_size == SIZE_WORD) && (bus.addr[1:0] != 2'b00));

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign out_of_bounds = |bus.addr[31:ADDR_W+2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];
  assign out_of_bounds  = 1'b0;
`endif

  assign req_legal = funct3_ok && !misaligned && !out_of_bounds;

  // Load formatting from the word read at the accepting edge.
  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = mem_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = addr_q[1] ? mem_q[31:16] : mem_q[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_fmt = {24'h0, lane_b};
      3'b101:  load_fmt = {16'h0, lane_h};
      default: load_fmt = mem_q;
    endcase
  end

  always_comb begin
    merged = mem_q;
    if (funct3_q[1:0] == SIZE_BYTE)
      merged[{addr_q[1:0], 3'b000} +: 8] = wr_data_q[7:0];
    else if (addr_q[1])
      merged[31:16] = wr_data_q;
    else
      merged[15:0] = wr_data_q;
  end

  // NOTE: every signal written in a combinational block gets a default at the top,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = req_idx;
    mem_wdata  = bus.wr_data;
    if (ena) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_legal) begin
              state_next = RESP;
            end else if (!bus.wr_ena) begin
              rd_en      = 1'b1;
              state_next = READ;
            end else if (req_size == SIZE_WORD) begin
              mem_we     = 1'b1;
              state_next = RESP;
            end else begin
              rd_en      = 1'b1;
              state_next = RMW;
            end
          end
        end
        READ: state_next = RESP;
        RMW: begin
          mem_we     = 1'b1;
          mem_waddr  = addr_q[ADDR_W+1:2];
          mem_wdata  = merged;
          state_next = RESP;
        end
        RESP: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: the RAM array is deliberately not reset so it maps onto block RAM; reset
  // only gates the write/read enables, which also kills an aborted RMW write.
  always_ff @(posedge clk) begin
    if (rst && ena) begin
      if (rd_en)  mem_q <= mem[req_idx];
      if (mem_we) mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q    <= '0;
      funct3_q  <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else if (ena) begin
      if (accept) begin
        addr_q    <= bus.addr[ADDR_W+1:0];
        funct3_q  <= bus.funct3;
        wr_data_q <= bus.wr_data[15:0];
        err_q     <= !req_legal;
      end
      if (state == READ) rd_data_q <= load_fmt;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.done      = (state == RESP);
  assign bus.err       = (state == RESP) && err_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_rv32i_data_memory_controller.sv
// Self-checking bench: driver pushes expected responses to a scoreboard queue,
// a negedge monitor pops and compares them when done is observed.
module tb_rv32i_data_memory_controller;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic ena;

  rv32i_data_memory_controller_if dif ();

  rv32i_data_memory_controller #(.DEPTH_WORDS(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rd  = '0;
  exp_t        mon_e;
  string       mon_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One request, issued when the controller is idle; measures accept-to-done latency.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int stall, input string tag);
    int n;
    if (!exp_err && !we) last_rd = exp_rd;
    exp_q.push_back('{rd: last_rd, err: exp_err});
    tag_q.push_back(tag);
    dif.req_valid = 1'b1;
    dif.wr_ena    = we;
    dif.funct3    = f3;
    dif.addr      = a;
    dif.wr_data   = d;
    check({tag, "/ready"}, 32'(dif.req_ready), 32'd1);
    @(posedge clk); #1;
    // Scrambled bus after accept: the controller must use its latched copy.
    dif.req_valid = 1'b0;
    dif.addr      = a ^ 32'h4;
    dif.wr_data   = ~d;
    if (stall > 0) begin
      ena = 1'b0;
      repeat (stall) @(posedge clk);
      #1;
      ena = 1'b1;
    end
    n = 1 + stall;
    while (!dif.done && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, n, exp_lat);
    @(posedge clk); #1;
    check({tag, "/done_1cyc"}, 32'(dif.done), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst && ena && dif.done) begin
      check("resp/outstanding", exp_q.size(), 32'd1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        check({mon_t, "/err"}, 32'(dif.err), 32'(mon_e.err));
        check({mon_t, "/rd_data"}, dif.rd_data, mon_e.rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    ena           = 1'b1;
    dif.req_valid = 1'b0;
    dif.wr_ena    = 1'b0;
    dif.funct3    = 3'b000;
    dif.addr      = '0;
    dif.wr_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset/ready",   32'(dif.req_ready), 32'd1);
    check("reset/done",    32'(dif.done),      32'd0);
    check("reset/err",     32'(dif.err),       32'd0);
    check("reset/rd_data", dif.rd_data,        32'd0);

    // we, f3, addr, wdata, err, rd, latency, stall, tag
    access(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0,            1, 0, "sw_10");
    access(0, 3'b010, 32'h10, 0,            0, 32'hDEADBEEF, 2, 0, "lw_10");

    access(1, 3'b010, 32'h20, 32'h80017F80, 0, 0,            1, 0, "sw_20");
    access(0, 3'b000, 32'h20, 0,            0, 32'hFFFFFF80, 2, 0, "lb_20");
    access(0, 3'b100, 32'h20, 0,            0, 32'h00000080, 2, 0, "lbu_20");
    access(0, 3'b000, 32'h21, 0,            0, 32'h0000007F, 2, 0, "lb_21");
    access(0, 3'b001, 32'h22, 0,            0, 32'hFFFF8001, 2, 0, "lh_22");
    access(0, 3'b101, 32'h22, 0,            0, 32'h00008001, 2, 0, "lhu_22");
    access(0, 3'b001, 32'h20, 0,            0, 32'h00007F80, 2, 0, "lh_20");
    access(0, 3'b100, 32'h23, 0,            0, 32'h00000080, 2, 0, "lbu_23");

    access(1, 3'b010, 32'h30, 32'h11223344, 0, 0,            1, 0, "sw_30");
    access(1, 3'b000, 32'h31, 32'h123456AA, 0, 0,            2, 0, "sb_31");
    access(1, 3'b001, 32'h32, 32'h9876BEEF, 0, 0,            2, 0, "sh_32");
    access(0, 3'b010, 32'h30, 0,            0, 32'hBEEFAA44, 2, 0, "lw_30");

    access(0, 3'b010, 32'h12, 0,            1, 0,            1, 0, "lw_mis");
    access(1, 3'b010, 32'h12, 32'h0,        1, 0,            1, 0, "sw_mis");
    access(1, 3'b001, 32'h33, 32'hFFFF,     1, 0,            1, 0, "sh_mis");
    access(0, 3'b011, 32'h10, 0,            1, 0,            1, 0, "f3_011");
    access(1, 3'b100, 32'h10, 32'h0,        1, 0,            1, 0, "st_f3_100");
    access(0, 3'b010, 32'h10, 0,            0, 32'hDEADBEEF, 2, 0, "lw_10_after_err");

    access(0, 3'b010, 32'h20, 0,            0, 32'h80017F80, 5, 3, "lw_stall");

    // Reset during the RMW of a byte store: the word must remain untouched.
    dif.req_valid = 1'b1;
    dif.wr_ena    = 1'b1;
    dif.funct3    = 3'b000;
    dif.addr      = 32'h31;
    dif.wr_data   = 32'h55;
    @(posedge clk); #1;
    dif.req_valid = 1'b0;
    check("rmw_abort/busy", 32'(dif.req_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_rd = '0;
    check("rmw_abort/ready",   32'(dif.req_ready), 32'd1);
    check("rmw_abort/done",    32'(dif.done),      32'd0);
    check("rmw_abort/rd_data", dif.rd_data,        32'd0);
    access(0, 3'b010, 32'h30, 0,            0, 32'hBEEFAA44, 2, 0, "lw_30_after_abort");

`ifdef DATA_MEM_BOUNDS_CHECK_EN
    access(0, 3'b010, DEPTH * 4,        0,            1, 0,            1, 0, "lw_oob");
    access(1, 3'b010, DEPTH * 4 + 'h40, 32'hCAFEF00D, 1, 0,            1, 0, "sw_oob");
    access(0, 3'b010, 32'h10,           0,            0, 32'hDEADBEEF, 2, 0, "lw_10_after_oob");
`else
    access(1, 3'b010, DEPTH * 4 + 'h40, 32'hCAFEF00D, 0, 0,            1, 0, "sw_wrap");
    access(0, 3'b010, 32'h40,           0,            0, 32'hCAFEF00D, 2, 0, "lw_wrap");
`endif

    repeat (2) @(posedge clk);
    check("scoreboard/drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
